// File: rtl/bin2bcd_stream_if.sv
// ----------------------------------------------------------------------------
// bin2bcd_stream_if
// Handshake bundle for the streaming binary-to-BCD converter.
//
// Input side : IN_VALID / IN_READY qualify BIN and SIGNED.
// Output side: OUT_VALID / OUT_READY qualify BCD, NEG, NDIGITS and OVERFLOW.
//
// modport master : the producer/consumer around the converter (drives inputs,
//                  accepts results)
// modport slave  : the converter itself
//
// Parameters must match the ones given to the bin2bcd_stream instance.
// ----------------------------------------------------------------------------
interface bin2bcd_stream_if #(
    parameter int IN_W   = 32,
    parameter int DIGITS = 10,
    parameter int NDIG_W = 4
);
    logic                  IN_VALID;
    logic                  IN_READY;
    logic [IN_W-1:0]       BIN;
    logic                  SIGNED;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic [DIGITS*4-1:0]   BCD;
    logic                  NEG;
    logic [NDIG_W-1:0]     NDIGITS;
    logic                  OVERFLOW;

    modport master (
        output IN_VALID, BIN, SIGNED, OUT_READY,
        input  IN_READY, OUT_VALID, BCD, NEG, NDIGITS, OVERFLOW
    );

    modport slave (
        input  IN_VALID, BIN, SIGNED, OUT_READY,
        output IN_READY, OUT_VALID, BCD, NEG, NDIGITS, OVERFLOW
    );
endinterface

// File: rtl/bin2bcd_stream.sv
// ----------------------------------------------------------------------------
// bin2bcd_stream
// Multi-cycle double-dabble binary-to-BCD converter with valid/ready
// handshakes. Supports two's-complement input (magnitude + sign out), a
// configurable number of shift-add iterations per clock, a significant-digit
// count for leading-zero blanking, and overflow when DIGITS is too small.
//
// Ports:
//   CLK    in  clock, rising edge
//   RESET  in  asynchronous, active-high reset
//   bus    bin2bcd_stream_if.slave
//            IN_VALID/IN_READY, BIN, SIGNED        input handshake + data
//            OUT_VALID/OUT_READY                   output handshake
//            BCD      packed BCD magnitude, digit 0 in [3:0]
//            NEG      result negative
//            NDIGITS  significant digits, 1..DIGITS
//            OVERFLOW magnitude >= 10^DIGITS (BCD holds it mod 10^DIGITS)
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | IN_READY=1, waiting for IN_VALID
// CONV  | running IN_W/SHIFTS_PER_CYCLE clock steps of double-dabble
// DONE  | OUT_VALID=1, result held until OUT_READY
// ----------------------------------------------------------------------------
module bin2bcd_stream #(
    parameter int IN_W             = 32,
    parameter int DIGITS           = 10,
    parameter int SHIFTS_PER_CYCLE = 1,
    parameter int CNT_W            = 6,
    parameter int NDIG_W           = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    bin2bcd_stream_if.slave        bus
);

    localparam int BCD_W = DIGITS * 4;
    localparam int ITERS = IN_W / SHIFTS_PER_CYCLE;

    if (IN_W < 2) begin : g_chk_in_w
        $error("bin2bcd_stream: IN_W must be at least 2");
    end
    if ((IN_W % SHIFTS_PER_CYCLE) != 0) begin : g_chk_spc
        $error("bin2bcd_stream: SHIFTS_PER_CYCLE must divide IN_W");
    end
    if (ITERS > ((1 << CNT_W) - 1)) begin : g_chk_cnt
        $error("bin2bcd_stream: CNT_W too small for IN_W/SHIFTS_PER_CYCLE");
    end
    if (DIGITS > ((1 << NDIG_W) - 1)) begin : g_chk_ndig
        $error("bin2bcd_stream: NDIG_W too small for DIGITS");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IN_W-1:0]     mag_q;
    logic [BCD_W-1:0]    bcd_work_q;
    logic                ovf_work_q;
    logic                neg_work_q;

    logic [BCD_W-1:0]    bcd_q;
    logic                neg_q;
    logic [NDIG_W-1:0]   ndig_q;
    logic                ovf_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [IN_W-1:0]     mag_in_d;
    logic                neg_in_d;
    logic [IN_W-1:0]     mag_d;
    logic [BCD_W-1:0]    bcd_work_d;
    logic                ovf_work_d;
    logic [NDIG_W-1:0]   ndig_d;

    // Magnitude of the incoming word. Negating the most negative value wraps
    // back to 2^(IN_W-1), which is exactly its magnitude when read unsigned.
    always_comb begin
        neg_in_d = bus.SIGNED & bus.BIN[IN_W-1];
        mag_in_d = bus.BIN;
        if (neg_in_d) begin
            mag_in_d = (~bus.BIN) + IN_W'(1);
        end
    end

    // One clock worth of double-dabble: SHIFTS_PER_CYCLE add-3/shift steps
    // chained combinationally. A 1 leaving the top digit means the value no
    // longer fits in DIGITS digits.
    always_comb begin
        bcd_work_d = bcd_work_q;
        mag_d      = mag_q;
        ovf_work_d = ovf_work_q;
        for (int s = 0; s < SHIFTS_PER_CYCLE; s++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (bcd_work_d[d*4 +: 4] >= 4'd5) begin
                    bcd_work_d[d*4 +: 4] = bcd_work_d[d*4 +: 4] + 4'd3;
                end
            end
            if (bcd_work_d[BCD_W-1]) begin
                ovf_work_d = 1'b1;
            end
            bcd_work_d = {bcd_work_d[BCD_W-2:0], mag_d[IN_W-1]};
            mag_d      = {mag_d[IN_W-2:0], 1'b0};
        end
    end

    // Significant digits of the value about to be published; zero shows as
    // one digit.
    always_comb begin
        ndig_d = NDIG_W'(1);
        for (int d = 1; d < DIGITS; d++) begin
            if (bcd_work_d[d*4 +: 4] != 4'd0) begin
                ndig_d = NDIG_W'(d + 1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mag_q       <= '0;
            bcd_work_q  <= '0;
            ovf_work_q  <= 1'b0;
            neg_work_q  <= 1'b0;
            bcd_q       <= '0;
            neg_q       <= 1'b0;
            ndig_q      <= NDIG_W'(1);
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.IN_VALID) begin
                        state_q    <= CONV;
                        cnt_q      <= CNT_W'(ITERS);
                        mag_q      <= mag_in_d;
                        neg_work_q <= neg_in_d;
                        bcd_work_q <= '0;
                        ovf_work_q <= 1'b0;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                    end
                end
                CONV: begin
                    bcd_work_q <= bcd_work_d;
                    mag_q      <= mag_d;
                    ovf_work_q <= ovf_work_d;
                    cnt_q      <= cnt_q - CNT_W'(1);
                    // Last step: publish straight from the combinational
                    // result so all outputs change on the same edge.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= DONE;
                        bcd_q       <= bcd_work_d;
                        neg_q       <= neg_work_q;
                        ovf_q       <= ovf_work_d;
                        ndig_q      <= ndig_d;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // IN_READY returns one cycle after the output handshake,
                    // never in the same cycle.
                    if (bus.OUT_READY) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.BCD       = bcd_q;
    assign bus.NEG       = neg_q;
    assign bus.NDIGITS   = ndig_q;
    assign bus.OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_stream.sv
// ----------------------------------------------------------------------------
// tb_bin2bcd_stream
// Three converter configurations side by side:
//   cfg0: IN_W=32, DIGITS=10, SHIFTS_PER_CYCLE=1 (defaults)
//   cfg1: IN_W=32, DIGITS=10, SHIFTS_PER_CYCLE=4
//   cfg2: IN_W=16, DIGITS=3,  SHIFTS_PER_CYCLE=1 (overflow + reset abort)
// Expected results come from a divide-by-ten reference model, queued when a
// word is offered and popped when the converter presents its result.
// ----------------------------------------------------------------------------
module tb_bin2bcd_stream;

    typedef struct packed {
        logic [39:0] bcd;
        logic        neg;
        logic [3:0]  ndig;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [31:0] bin;
        logic        sgn;
        logic        hold;
    } vec_t;

    logic clk;
    int   n_checks;
    int   n_errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input int cfg, input string tag,
                         input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL cfg%0d %s: got 0x%0h expected 0x%0h", cfg, tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] bin, input logic sgn,
                                   input int in_w, input int digits);
        exp_t            e;
        longint unsigned mag;
        longint unsigned lim;
        longint unsigned dig;
        mag   = 64'(bin) & ((64'd1 << in_w) - 64'd1);
        e.neg = sgn && (((mag >> (in_w - 1)) & 64'd1) == 64'd1);
        if (e.neg) mag = (64'd1 << in_w) - mag;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        e.ovf  = (mag >= lim);
        e.bcd  = '0;
        e.ndig = 4'd1;
        for (int d = 0; d < digits; d++) begin
            dig = mag % 10;
            mag = mag / 10;
            e.bcd = e.bcd | 40'(dig << (4 * d));
            if (dig != 0) e.ndig = 4'(d + 1);
        end
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_cfg
        localparam int IW    = (g == 2) ? 16 : 32;
        localparam int DG    = (g == 2) ? 3 : 10;
        localparam int SPC   = (g == 1) ? 4 : 1;
        localparam int ITERS = IW / SPC;

        logic rst;
        bit   done;
        exp_t sb[$];

        bin2bcd_stream_if #(.IN_W(IW), .DIGITS(DG), .NDIG_W(4)) itf ();

        bin2bcd_stream #(
            .IN_W(IW), .DIGITS(DG), .SHIFTS_PER_CYCLE(SPC), .CNT_W(6), .NDIG_W(4)
        ) dut (
            .CLK(clk),
            .RESET(rst),
            .bus(itf.slave)
        );

        initial begin : stim
            vec_t vq[$];
            vec_t v;
            exp_t e;
            int   lat;
            int   spur;
            done          = 1'b0;
            rst           = 1'b1;
            itf.IN_VALID  = 1'b0;
            itf.BIN       = '0;
            itf.SIGNED    = 1'b0;
            itf.OUT_READY = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            check(g, "rst_in_ready",  64'(itf.IN_READY),  64'd1);
            check(g, "rst_out_valid", 64'(itf.OUT_VALID), 64'd0);
            check(g, "rst_bcd",       64'(itf.BCD),       64'd0);
            check(g, "rst_ndigits",   64'(itf.NDIGITS),   64'd1);
            @(negedge clk) rst = 1'b0;
            @(posedge clk);
            #1;

            if (g == 0) begin
                vq.push_back('{32'hFFFF_FFFF, 1'b0, 1'b0});
                vq.push_back('{32'd0,         1'b0, 1'b0});
                vq.push_back('{32'd7,         1'b0, 1'b0});
                vq.push_back('{32'd1000,      1'b0, 1'b0});
                vq.push_back('{32'h8000_0000, 1'b1, 1'b0});
                vq.push_back('{32'hFFFF_FFFF, 1'b1, 1'b0});
                vq.push_back('{32'h8000_0000, 1'b0, 1'b0});
                vq.push_back('{32'd123456789, 1'b0, 1'b1});
                vq.push_back('{32'd9876543,   1'b1, 1'b0});
                for (int i = 0; i < 4; i++)
                    vq.push_back('{32'($urandom), 1'($urandom_range(0, 1)), 1'b0});
            end else if (g == 1) begin
                vq.push_back('{32'd12345678,  1'b0, 1'b0});
                vq.push_back('{32'hFFFF_FFFE, 1'b1, 1'b0});
                for (int i = 0; i < 3; i++)
                    vq.push_back('{32'($urandom), 1'($urandom_range(0, 1)), 1'b0});
            end else begin
                vq.push_back('{32'd1000,   1'b0, 1'b0});
                vq.push_back('{32'd999,    1'b0, 1'b0});
                vq.push_back('{32'h8000,   1'b1, 1'b0});
                vq.push_back('{32'hFFFF,   1'b0, 1'b0});
                vq.push_back('{32'hFFFF,   1'b1, 1'b0});
            end

            foreach (vq[i]) begin
                v   = vq[i];
                lat = 0;
                while (!itf.IN_READY && lat < 100) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                check(g, "ready_wait", 64'(itf.IN_READY), 64'd1);
                itf.BIN       = v.bin[IW-1:0];
                itf.SIGNED    = v.sgn;
                itf.IN_VALID  = 1'b1;
                itf.OUT_READY = ~v.hold;
                sb.push_back(model(v.bin, v.sgn, IW, DG));
                @(posedge clk);
                #1;
                itf.IN_VALID = 1'b0;
                itf.BIN      = IW'($urandom);
                itf.SIGNED   = 1'($urandom_range(0, 1));
                check(g, "conv_in_ready", 64'(itf.IN_READY), 64'd0);
                lat = 0;
                while (!itf.OUT_VALID && lat < 200) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                check(g, "latency", 64'(lat), 64'(ITERS));
                e = sb.pop_front();
                if (v.hold) begin
                    for (int k = 0; k < 10; k++) begin
                        itf.IN_VALID = 1'b1;
                        itf.BIN      = IW'($urandom);
                        check(g, "hold_out_valid", 64'(itf.OUT_VALID), 64'd1);
                        check(g, "hold_in_ready",  64'(itf.IN_READY),  64'd0);
                        check(g, "hold_bcd",       64'(itf.BCD),       64'(e.bcd));
                        check(g, "hold_ndigits",   64'(itf.NDIGITS),   64'(e.ndig));
                        @(posedge clk);
                        #1;
                    end
                    itf.IN_VALID  = 1'b0;
                    itf.OUT_READY = 1'b1;
                end
                check(g, "bcd",      64'(itf.BCD),      64'(e.bcd));
                check(g, "neg",      64'(itf.NEG),      64'(e.neg));
                check(g, "ndigits",  64'(itf.NDIGITS),  64'(e.ndig));
                check(g, "overflow", 64'(itf.OVERFLOW), 64'(e.ovf));
                @(posedge clk);
                #1;
                check(g, "hs_out_valid", 64'(itf.OUT_VALID), 64'd0);
                check(g, "hs_in_ready",  64'(itf.IN_READY),  64'd1);
                check(g, "keep_bcd",     64'(itf.BCD),       64'(e.bcd));
            end

            if (g == 2) begin
                itf.BIN      = IW'(500);
                itf.SIGNED   = 1'b0;
                itf.IN_VALID = 1'b1;
                @(posedge clk);
                #1;
                itf.IN_VALID = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                rst = 1'b1;
                #1;
                check(g, "abort_in_ready",  64'(itf.IN_READY),  64'd1);
                check(g, "abort_out_valid", 64'(itf.OUT_VALID), 64'd0);
                check(g, "abort_bcd",       64'(itf.BCD),       64'd0);
                check(g, "abort_neg",       64'(itf.NEG),       64'd0);
                check(g, "abort_ndigits",   64'(itf.NDIGITS),   64'd1);
                check(g, "abort_overflow",  64'(itf.OVERFLOW),  64'd0);
                @(negedge clk) rst = 1'b0;
                spur = 0;
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    if (itf.OUT_VALID) spur++;
                end
                check(g, "abort_no_output", 64'(spur), 64'd0);
                check(g, "abort_idle_ready", 64'(itf.IN_READY), 64'd1);
            end
            done = 1'b1;
        end
    end

    initial begin : supervisor
        int  waited;
        logic all_done;
        n_checks = 0;
        n_errors = 0;
        waited   = 0;
        all_done = 1'b0;
        while (!all_done && waited < 20000) begin
            @(posedge clk);
            waited++;
            all_done = gen_cfg[0].done && gen_cfg[1].done && gen_cfg[2].done;
        end
        check(9, "timeout", 64'(all_done), 64'd1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
